riscv_register_writeback: RTL and testbench

RISCV_REGISTER_WRITEBACK -- requirements
Module: riscv_register_writeback

---
 rtl/riscv_register_writeback_pkg.sv | 22 ++
 rtl/riscv_register_writeback_if.sv | 33 +++
 rtl/riscv_configs.v | 6 +
 rtl/riscv_scoreboard.sv | 63 ++++++
 rtl/riscv_register_writeback.sv | 64 ++++++
 tb/tb_riscv_register_writeback.sv | 256 +++++++++++++++++++++++++
 6 files changed

// File: rtl/riscv_register_writeback_pkg.sv
// Types and constants shared by the register file, its scoreboard and the bus interface.
`include "riscv_configs.v"

package riscv_register_writeback_pkg;
    localparam int XLEN      = `XLEN;
    localparam int REG_IDX_W = `REG_IDX_W;
    localparam int NUM_REGS  = 1 << REG_IDX_W;
    localparam int CNT_W     = REG_IDX_W + 1;

    typedef logic [XLEN-1:0]      xlen_t;
    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    typedef logic [NUM_REGS-1:0]  reg_vec_t;
    typedef logic [CNT_W-1:0]     cnt_t;

    // One-hot select of a register; x0 never appears in any busy-related vector.
    function automatic reg_vec_t idx_onehot(input logic en, input reg_idx_t idx);
        reg_vec_t v;
        v = '0;
        if (en && idx != '0) v[idx] = 1'b1;
        return v;
    endfunction
endpackage

// File: rtl/riscv_register_writeback_if.sv
// Read, issue and writeback signals of the register file, with master/slave views.
interface riscv_register_writeback_if;
    import riscv_register_writeback_pkg::*;

    reg_idx_t i_rs1_addr;
    reg_idx_t i_rs2_addr;
    xlen_t    o_rs1_data;
    xlen_t    o_rs2_data;
    logic     i_issue_valid;
    reg_idx_t i_issue_rd;
    logic     i_issue_rs1_use;
    logic     i_issue_rs2_use;
    logic     o_register_stall;
    logic     i_wb_valid;
    reg_idx_t i_wb_rd;
    xlen_t    i_wb_data;
    cnt_t     o_pending_cnt;
    reg_vec_t o_busy_vec;

    // Issue handshake: an issue is taken on a clock edge where i_issue_valid is
    // high and o_register_stall is low (and no flush); a stalled issue must hold.
    modport slave (
        input  i_rs1_addr, i_rs2_addr, i_issue_valid, i_issue_rd,
        input  i_issue_rs1_use, i_issue_rs2_use, i_wb_valid, i_wb_rd, i_wb_data,
        output o_rs1_data, o_rs2_data, o_register_stall, o_pending_cnt, o_busy_vec
    );

    modport master (
        output i_rs1_addr, i_rs2_addr, i_issue_valid, i_issue_rd,
        output i_issue_rs1_use, i_issue_rs2_use, i_wb_valid, i_wb_rd, i_wb_data,
        input  o_rs1_data, o_rs2_data, o_register_stall, o_pending_cnt, o_busy_vec
    );
endinterface

// File: rtl/riscv_configs.v
// Shared core-wide configuration: datapath width and register index width.
`ifndef RISCV_CONFIGS_V
`define RISCV_CONFIGS_V
`define XLEN 32
`define REG_IDX_W 5
`endif

// File: rtl/riscv_scoreboard.sv
// Busy-bit scoreboard: tracks registers with an outstanding write and raises the issue stall.
module riscv_scoreboard
    import riscv_register_writeback_pkg::*;
(
    input  logic     clk_i,
    input  logic     rst_ni,
    input  logic     clr_i,
    input  logic     issue_valid_i,
    input  reg_idx_t issue_rd_i,
    input  reg_idx_t issue_rs1_i,
    input  reg_idx_t issue_rs2_i,
    input  logic     issue_rs1_use_i,
    input  logic     issue_rs2_use_i,
    input  logic     wb_valid_i,
    input  reg_idx_t wb_rd_i,
    output logic     stall_o,
    output cnt_t     pending_cnt_o,
    output reg_vec_t busy_o
);
    reg_vec_t busy_q, busy_d;
    cnt_t     cnt_q, cnt_d;
    reg_vec_t wb_vec, eff_busy, set_vec, clr_vec;
    logic     accept, inc, dec;

    always_comb begin
        wb_vec   = idx_onehot(wb_valid_i, wb_rd_i);
        // A writeback landing this cycle releases its register for the same-cycle issue.
        eff_busy = busy_q & ~wb_vec;
        stall_o  = issue_valid_i && !clr_i &&
                   ((issue_rs1_use_i && eff_busy[issue_rs1_i]) ||
                    (issue_rs2_use_i && eff_busy[issue_rs2_i]) ||
                    (issue_rd_i != '0 && eff_busy[issue_rd_i]));
        accept   = issue_valid_i && !stall_o && !clr_i;
        set_vec  = idx_onehot(accept, issue_rd_i);
        clr_vec  = wb_vec & busy_q;
        inc      = |(set_vec & ~busy_q);
        dec      = |(clr_vec & ~set_vec);
        busy_d   = (busy_q & ~clr_vec) | set_vec;
        cnt_d    = cnt_q;
        if (inc && !dec) begin
            cnt_d = cnt_q + cnt_t'(1);
        end else if (dec && !inc) begin
            cnt_d = cnt_q - cnt_t'(1);
        end
        if (clr_i) begin
            busy_d = '0;
            cnt_d  = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign pending_cnt_o = cnt_q;
    assign busy_o        = busy_q;
endmodule

// File: rtl/riscv_register_writeback.sv
// Integer register file x1..x31 with writeback bypass and a busy-bit scoreboard for issue stalls.
module riscv_register_writeback
    import riscv_register_writeback_pkg::*;
#(
    parameter xlen_t REGISTER_INIT = '0
)
(
    input logic                       i_clk,
    input logic                       i_rstn,
    input logic                       i_clr,
    riscv_register_writeback_if.slave rf
);
    xlen_t regs_q [1:NUM_REGS-1];

    // The flush does not gate the array write: completed results are architectural.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                regs_q[i] <= REGISTER_INIT;
            end
        end else if (rf.i_wb_valid && rf.i_wb_rd != '0) begin
            regs_q[rf.i_wb_rd] <= rf.i_wb_data;
        end
    end

    always_comb begin
        rf.o_rs1_data = '0;
        if (rf.i_rs1_addr != '0) begin
            if (rf.i_wb_valid && rf.i_wb_rd == rf.i_rs1_addr) begin
                rf.o_rs1_data = rf.i_wb_data;
            end else begin
                rf.o_rs1_data = regs_q[rf.i_rs1_addr];
            end
        end
    end

    always_comb begin
        rf.o_rs2_data = '0;
        if (rf.i_rs2_addr != '0) begin
            if (rf.i_wb_valid && rf.i_wb_rd == rf.i_rs2_addr) begin
                rf.o_rs2_data = rf.i_wb_data;
            end else begin
                rf.o_rs2_data = regs_q[rf.i_rs2_addr];
            end
        end
    end

    riscv_scoreboard u_scoreboard (
        .clk_i           (i_clk),
        .rst_ni          (i_rstn),
        .clr_i           (i_clr),
        .issue_valid_i   (rf.i_issue_valid),
        .issue_rd_i      (rf.i_issue_rd),
        .issue_rs1_i     (rf.i_rs1_addr),
        .issue_rs2_i     (rf.i_rs2_addr),
        .issue_rs1_use_i (rf.i_issue_rs1_use),
        .issue_rs2_use_i (rf.i_issue_rs2_use),
        .wb_valid_i      (rf.i_wb_valid),
        .wb_rd_i         (rf.i_wb_rd),
        .stall_o         (rf.o_register_stall),
        .pending_cnt_o   (rf.o_pending_cnt),
        .busy_o          (rf.o_busy_vec)
    );
endmodule

// File: tb/tb_riscv_register_writeback.sv
// Self-checking bench for riscv_register_writeback: directed scenarios plus randomized traffic.
module tb_riscv_register_writeback;
    import riscv_register_writeback_pkg::*;

    localparam xlen_t TB_INIT = 32'hDEAD_BEEF;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic clr = 1'b0;

    riscv_register_writeback_if rf();

    riscv_register_writeback #(.REGISTER_INIT(TB_INIT)) dut (
        .i_clk  (clk),
        .i_rstn (rstn),
        .i_clr  (clr),
        .rf     (rf)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: architectural register values and a set of pending destinations.
    xlen_t m_regs [NUM_REGS];
    bit    m_busy [NUM_REGS];

    task automatic m_reset();
        for (int r = 0; r < NUM_REGS; r++) begin
            m_regs[r] = TB_INIT;
            m_busy[r] = 1'b0;
        end
    endtask

    function automatic xlen_t m_read(input int addr);
        if (addr == 0) return '0;
        if (rf.i_wb_valid && int'(rf.i_wb_rd) == addr) return rf.i_wb_data;
        return m_regs[addr];
    endfunction

    function automatic bit m_blocked(input int r);
        return r != 0 && m_busy[r] && !(rf.i_wb_valid && int'(rf.i_wb_rd) == r);
    endfunction

    function automatic bit m_stall();
        if (clr || !rf.i_issue_valid) return 1'b0;
        return (rf.i_issue_rs1_use && m_blocked(int'(rf.i_rs1_addr))) ||
               (rf.i_issue_rs2_use && m_blocked(int'(rf.i_rs2_addr))) ||
               m_blocked(int'(rf.i_issue_rd));
    endfunction

    function automatic int m_count();
        int n = 0;
        for (int r = 0; r < NUM_REGS; r++) n += int'(m_busy[r]);
        return n;
    endfunction

    function automatic reg_vec_t m_busy_vec();
        reg_vec_t v = '0;
        for (int r = 0; r < NUM_REGS; r++) v[r] = m_busy[r];
        return v;
    endfunction

    task automatic m_edge();
        bit acc;
        acc = rf.i_issue_valid && !m_stall() && !clr;
        if (rf.i_wb_valid && rf.i_wb_rd != '0) m_regs[rf.i_wb_rd] = rf.i_wb_data;
        if (clr) begin
            for (int r = 0; r < NUM_REGS; r++) m_busy[r] = 1'b0;
        end else begin
            if (rf.i_wb_valid) m_busy[rf.i_wb_rd] = 1'b0;
            if (acc && rf.i_issue_rd != '0) m_busy[rf.i_issue_rd] = 1'b1;
        end
    endtask

    task automatic idle();
        rf.i_rs1_addr = '0; rf.i_rs2_addr = '0;
        rf.i_issue_valid = 1'b0; rf.i_issue_rd = '0;
        rf.i_issue_rs1_use = 1'b0; rf.i_issue_rs2_use = 1'b0;
        rf.i_wb_valid = 1'b0; rf.i_wb_rd = '0; rf.i_wb_data = '0;
        clr = 1'b0;
    endtask

    task automatic tick();
        m_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        rf.i_rs1_addr = 5'd5; rf.i_rs2_addr = 5'd0;
        #1;
        n_checks++; if (rf.o_rs1_data !== TB_INIT) begin n_errors++; $display("FAIL reset_x5 got=%h exp=%h", rf.o_rs1_data, TB_INIT); end
        n_checks++; if (rf.o_rs2_data !== 32'd0) begin n_errors++; $display("FAIL reset_x0 got=%h exp=0", rf.o_rs2_data); end
        n_checks++; if (rf.o_pending_cnt !== 6'd0) begin n_errors++; $display("FAIL reset_cnt got=%0d exp=0", rf.o_pending_cnt); end
        n_checks++; if (rf.o_busy_vec !== 32'd0) begin n_errors++; $display("FAIL reset_busy got=%h exp=0", rf.o_busy_vec); end
        rstn = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (rf.o_rs1_data !== TB_INIT) begin n_errors++; $display("FAIL post_reset_x5 got=%h exp=%h", rf.o_rs1_data, TB_INIT); end
    endtask

    task automatic test_raw_hazard();
        idle(); rf.i_issue_valid = 1'b1; rf.i_issue_rd = 5'd3;
        #1;
        n_checks++; if (rf.o_register_stall !== 1'b0) begin n_errors++; $display("FAIL raw_first_issue_stall got=%b exp=0", rf.o_register_stall); end
        tick();
        n_checks++; if (rf.o_pending_cnt !== 6'd1) begin n_errors++; $display("FAIL raw_cnt_after_issue got=%0d exp=1", rf.o_pending_cnt); end
        idle(); rf.i_issue_valid = 1'b1; rf.i_rs1_addr = 5'd3; rf.i_issue_rs1_use = 1'b1;
        #1;
        n_checks++; if (rf.o_register_stall !== 1'b1) begin n_errors++; $display("FAIL raw_stall got=%b exp=1", rf.o_register_stall); end
        tick();
        n_checks++; if (rf.o_pending_cnt !== 6'd1) begin n_errors++; $display("FAIL raw_cnt_while_stalled got=%0d exp=1", rf.o_pending_cnt); end
        rf.i_wb_valid = 1'b1; rf.i_wb_rd = 5'd3; rf.i_wb_data = 32'hA5;
        #1;
        n_checks++; if (rf.o_register_stall !== 1'b0) begin n_errors++; $display("FAIL raw_wb_release_stall got=%b exp=0", rf.o_register_stall); end
        n_checks++; if (rf.o_rs1_data !== 32'hA5) begin n_errors++; $display("FAIL raw_bypass got=%h exp=a5", rf.o_rs1_data); end
        tick();
        n_checks++; if (rf.o_pending_cnt !== 6'd0) begin n_errors++; $display("FAIL raw_cnt_after_wb got=%0d exp=0", rf.o_pending_cnt); end
        idle(); rf.i_rs1_addr = 5'd3;
        #1;
        n_checks++; if (rf.o_rs1_data !== 32'hA5) begin n_errors++; $display("FAIL raw_stored got=%h exp=a5", rf.o_rs1_data); end
    endtask

    task automatic test_x0();
        idle(); rf.i_issue_valid = 1'b1; rf.i_issue_rd = 5'd0;
        #1;
        n_checks++; if (rf.o_register_stall !== 1'b0) begin n_errors++; $display("FAIL x0_issue_stall got=%b exp=0", rf.o_register_stall); end
        tick();
        n_checks++; if (rf.o_busy_vec !== 32'd0) begin n_errors++; $display("FAIL x0_busy got=%h exp=0", rf.o_busy_vec); end
        idle(); rf.i_wb_valid = 1'b1; rf.i_wb_rd = 5'd0; rf.i_wb_data = 32'hFF;
        #1;
        n_checks++; if (rf.o_rs1_data !== 32'd0) begin n_errors++; $display("FAIL x0_bypass got=%h exp=0", rf.o_rs1_data); end
        tick();
        idle();
        #1;
        n_checks++; if (rf.o_rs1_data !== 32'd0) begin n_errors++; $display("FAIL x0_read got=%h exp=0", rf.o_rs1_data); end
        n_checks++; if (rf.o_pending_cnt !== 6'd0) begin n_errors++; $display("FAIL x0_cnt got=%0d exp=0", rf.o_pending_cnt); end
    endtask

    task automatic test_set_wins();
        idle(); rf.i_issue_valid = 1'b1; rf.i_issue_rd = 5'd7;
        tick();
        n_checks++; if (rf.o_busy_vec !== 32'h80) begin n_errors++; $display("FAIL setwin_busy_before got=%h exp=80", rf.o_busy_vec); end
        rf.i_wb_valid = 1'b1; rf.i_wb_rd = 5'd7; rf.i_wb_data = 32'h77;
        #1;
        n_checks++; if (rf.o_register_stall !== 1'b0) begin n_errors++; $display("FAIL setwin_stall got=%b exp=0", rf.o_register_stall); end
        tick();
        n_checks++; if (rf.o_busy_vec !== 32'h80) begin n_errors++; $display("FAIL setwin_busy_after got=%h exp=80", rf.o_busy_vec); end
        n_checks++; if (rf.o_pending_cnt !== 6'd1) begin n_errors++; $display("FAIL setwin_cnt got=%0d exp=1", rf.o_pending_cnt); end
        idle(); rf.i_wb_valid = 1'b1; rf.i_wb_rd = 5'd7; rf.i_wb_data = 32'h78;
        tick();
        idle(); rf.i_rs2_addr = 5'd7;
        #1;
        n_checks++; if (rf.o_pending_cnt !== 6'd0) begin n_errors++; $display("FAIL setwin_cnt_drain got=%0d exp=0", rf.o_pending_cnt); end
        n_checks++; if (rf.o_rs2_data !== 32'h78) begin n_errors++; $display("FAIL setwin_data got=%h exp=78", rf.o_rs2_data); end
    endtask

    task automatic test_fill_and_clear();
        idle();
        for (int r = 1; r < NUM_REGS; r++) begin
            rf.i_issue_valid = 1'b1; rf.i_issue_rd = reg_idx_t'(r);
            tick();
        end
        n_checks++; if (rf.o_pending_cnt !== 6'd31) begin n_errors++; $display("FAIL fill_cnt got=%0d exp=31", rf.o_pending_cnt); end
        n_checks++; if (rf.o_busy_vec !== 32'hFFFF_FFFE) begin n_errors++; $display("FAIL fill_busy got=%h exp=fffffffe", rf.o_busy_vec); end
        rf.i_issue_rd = 5'd5;
        #1;
        n_checks++; if (rf.o_register_stall !== 1'b1) begin n_errors++; $display("FAIL fill_waw_stall got=%b exp=1", rf.o_register_stall); end
        clr = 1'b1; rf.i_rs1_addr = 5'd5; rf.i_issue_rs1_use = 1'b1;
        rf.i_wb_valid = 1'b1; rf.i_wb_rd = 5'd9; rf.i_wb_data = 32'h1234_0009;
        #1;
        n_checks++; if (rf.o_register_stall !== 1'b0) begin n_errors++; $display("FAIL clr_forces_stall_low got=%b exp=0", rf.o_register_stall); end
        tick();
        idle(); rf.i_rs1_addr = 5'd9;
        #1;
        n_checks++; if (rf.o_pending_cnt !== 6'd0) begin n_errors++; $display("FAIL clr_cnt got=%0d exp=0", rf.o_pending_cnt); end
        n_checks++; if (rf.o_busy_vec !== 32'd0) begin n_errors++; $display("FAIL clr_busy got=%h exp=0", rf.o_busy_vec); end
        n_checks++; if (rf.o_rs1_data !== 32'h1234_0009) begin n_errors++; $display("FAIL clr_wb_commit got=%h exp=12340009", rf.o_rs1_data); end
    endtask

    task automatic test_async_reset();
        idle();
        for (int r = 1; r <= 4; r++) begin
            rf.i_issue_valid = 1'b1; rf.i_issue_rd = reg_idx_t'(r);
            tick();
        end
        idle(); rf.i_rs1_addr = 5'd3;
        n_checks++; if (rf.o_pending_cnt !== 6'd4) begin n_errors++; $display("FAIL arst_cnt_before got=%0d exp=4", rf.o_pending_cnt); end
        #2;
        rstn = 1'b0;
        m_reset();
        #1;
        n_checks++; if (rf.o_pending_cnt !== 6'd0) begin n_errors++; $display("FAIL arst_cnt got=%0d exp=0", rf.o_pending_cnt); end
        n_checks++; if (rf.o_busy_vec !== 32'd0) begin n_errors++; $display("FAIL arst_busy got=%h exp=0", rf.o_busy_vec); end
        n_checks++; if (rf.o_rs1_data !== TB_INIT) begin n_errors++; $display("FAIL arst_x3 got=%h exp=%h", rf.o_rs1_data, TB_INIT); end
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;
        rf.i_issue_valid = 1'b1; rf.i_issue_rd = 5'd2;
        #1;
        n_checks++; if (rf.o_register_stall !== 1'b0) begin n_errors++; $display("FAIL arst_release_stall got=%b exp=0", rf.o_register_stall); end
        tick();
        n_checks++; if (rf.o_pending_cnt !== 6'd1) begin n_errors++; $display("FAIL arst_release_cnt got=%0d exp=1", rf.o_pending_cnt); end
        idle(); rf.i_wb_valid = 1'b1; rf.i_wb_rd = 5'd2; rf.i_wb_data = 32'h22;
        tick();
        idle();
    endtask

    task automatic test_random();
        int pend [$];
        for (int it = 0; it < 400; it++) begin
            idle();
            pend.delete();
            for (int r = 1; r < NUM_REGS; r++) if (m_busy[r]) pend.push_back(r);
            rf.i_issue_valid   = 1'($urandom_range(0, 1));
            rf.i_issue_rd      = reg_idx_t'($urandom_range(0, 31));
            rf.i_rs1_addr      = reg_idx_t'($urandom_range(0, 31));
            rf.i_rs2_addr      = reg_idx_t'($urandom_range(0, 31));
            rf.i_issue_rs1_use = 1'($urandom_range(0, 1));
            rf.i_issue_rs2_use = 1'($urandom_range(0, 1));
            rf.i_wb_valid      = ($urandom_range(0, 9) < 7);
            if (pend.size() > 0 && $urandom_range(0, 3) != 0)
                rf.i_wb_rd = reg_idx_t'(pend[$urandom_range(0, pend.size() - 1)]);
            else
                rf.i_wb_rd = reg_idx_t'($urandom_range(0, 31));
            rf.i_wb_data = xlen_t'($urandom);
            clr = ($urandom_range(0, 31) == 0);
            #1;
            n_checks++; if (rf.o_rs1_data !== m_read(int'(rf.i_rs1_addr))) begin n_errors++; $display("FAIL rnd_rs1 it=%0d got=%h exp=%h", it, rf.o_rs1_data, m_read(int'(rf.i_rs1_addr))); end
            n_checks++; if (rf.o_rs2_data !== m_read(int'(rf.i_rs2_addr))) begin n_errors++; $display("FAIL rnd_rs2 it=%0d got=%h exp=%h", it, rf.o_rs2_data, m_read(int'(rf.i_rs2_addr))); end
            n_checks++; if (rf.o_register_stall !== m_stall()) begin n_errors++; $display("FAIL rnd_stall it=%0d got=%b exp=%b", it, rf.o_register_stall, m_stall()); end
            tick();
            n_checks++; if (int'(rf.o_pending_cnt) != m_count()) begin n_errors++; $display("FAIL rnd_cnt it=%0d got=%0d exp=%0d", it, rf.o_pending_cnt, m_count()); end
            n_checks++; if (rf.o_busy_vec !== m_busy_vec()) begin n_errors++; $display("FAIL rnd_busy it=%0d got=%h exp=%h", it, rf.o_busy_vec, m_busy_vec()); end
        end
        idle();
    endtask

    initial begin
        idle();
        rstn = 1'b0;
        m_reset();
        test_reset();
        test_raw_hazard();
        test_x0();
        test_set_wins();
        test_fill_and_clear();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
